xif_copro_issue_predecoder: RTL and testbench
=============================================

# xif_copro_issue_predecoder

Parametrised issue-stage front end for the XIF coprocessor. It matches offloaded instructions against a configurable table of `NUM_INSTR` entries using first-match priority, and returns a registered issue response. Accepted instructions and their operands are buffered in an in-order scoreboard FIFO. Instructions are released to the coprocessor datapath only once the core commits them; killed instructions are discarded. It sits between the core's CV-X-IF issue/commit interfaces and the coprocessor execution units.

## Interface
- `NUM_INSTR`, 3: number of offload table entries.
- `OFFLOAD_INSTR`, package default table: array[NUM_INSTR] of {instr, instr_mask, prd_rsp}.
- `ID_WIDTH`, 4: instruction ID width.
- `SB_DEPTH`, 4: scoreboard entries; power of two, ≥2.
- `IDX_WIDTH`, $clog2(NUM_INSTR) (min 1): matched-entry index width.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `issue_valid_i` in 1; `issue_ready_o` out 1: issue handshake.
- `issue_instr_i` in 32; `issue_id_i` in ID_WIDTH: instruction word and ID.
- `issue_rs_i` in 2×32; `issue_rs_valid_i` in 2: source operands and their valid flags.
- `resp_valid_o` out 1: one-cycle response pulse.
- `resp_id_o` out ID_WIDTH: ID of the responded instruction.
- `resp_accept_o`, `resp_writeback_o`, `resp_loadstore_o` out 1 each: response flags.
- `commit_valid_i` in 1; `commit_id_i` in ID_WIDTH; `commit_kill_i` in 1: commit interface.
- `disp_valid_o` out 1; `disp_ready_i` in 1: dispatch handshake.
- `disp_instr_o` out 32; `disp_id_o` out ID_WIDTH; `disp_idx_o` out IDX_WIDTH; `disp_rs_o` out 2×32: dispatched instruction, ID, table index and operands.
- `err_o` out 1: sticky commit-protocol error.
- `stat_accept_o`, `stat_reject_o`, `stat_kill_o` out 32 each: statistics counters (see Configuration).

## Operation
- Match rule: entry i hits when `(issue_instr_i & instr_mask[i]) == instr[i]`. The lowest-index hit wins. `disp_idx_o` carries the winning index.
- Ready rule: `issue_ready_o` = !full && (no hit || operands ready). Operands ready means every `use_gprs[k]`=1 of the winning entry has `issue_rs_valid_i[k]`=1. An instruction with no hit handshakes without waiting for operands.
- Handshake with a hit: the response carries the entry's `prd_rsp` flags with accept=1. An entry {instr, id, idx, rs, state=PEND} is pushed to the scoreboard tail. Unused rs slots are stored as 0.
- Handshake with no hit: the response is accept=0, writeback=0, loadstore=0. Nothing is pushed.
- Each entry is in one of three states: PEND, COMMIT, KILL.
- Commits arrive in program order. A commit pointer tracks the oldest PEND entry.
  - `commit_id_i` matches that entry: the entry moves to COMMIT (kill=0) or KILL (kill=1), and the pointer advances.
  - ID mismatch, or no PEND entry present: the commit is ignored and `err_o` is set. It stays set until reset.
  - Commits for rejected instructions carry IDs that never match a PEND entry. The core must not send them; they are treated as errors.
- Head handling:
  - A COMMIT head asserts `disp_valid_o`. It pops when `disp_ready_i`=1.
  - A KILL head pops silently in one cycle, with `disp_valid_o`=0.
  - A PEND head, or an empty scoreboard, drives `disp_valid_o`=0.
- Pointers are log2(SB_DEPTH)+1 bits wide, with a wrap bit. Full and empty are decided from the pointers alone.

## Timing
- Reset values: `resp_valid_o`, `resp_*`, `resp_id_o`, `disp_valid_o`, `err_o` and all stat counters are 0. The scoreboard is empty.
- `issue_ready_o` is combinational from the inputs and occupancy.
- Issue handshake in cycle N: `resp_valid_o` pulses in N+1. The pushed entry is visible in N+1. Back-to-back issues produce back-to-back responses.
- A commit in cycle N changes the entry state in N+1. The earliest dispatch is N+1, when the entry is at the head. Commit may coincide with that entry's `resp_valid_o` cycle.
- A push and a pop in the same cycle are both honoured.
- When full, `issue_ready_o`=0 even if a pop happens that cycle. There is no same-cycle bypass.
- `disp_*` outputs are held stable while `disp_valid_o`=1 and `disp_ready_i`=0.
- Reset asserted mid-operation clears all entries, pointers and `err_o` asynchronously.

## Configuration
- `XIF_COPRO_PRD_STATS_EN` defined: three 32-bit saturating counters are compiled in.
  - `stat_accept_o` counts accepted handshakes.
  - `stat_reject_o` counts rejected handshakes.
  - `stat_kill_o` counts killed entries popped.
- Not defined: the stat ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, then issue `0x0400702B` with rs_valid=01, id=3: `resp_valid_o` in N+1 with accept=1, writeback=0, `resp_id_o`=3. Commit id 3, kill=0: `disp_valid_o`=1 with idx=0, instr=`0x0400702B`, `disp_rs_o[0]` equal to the issued operand.
- Duplicate-match priority: issue `0x0600702B`, which hits entries 1 and 2: accepted with `disp_idx_o`=1.
- Issue `0x0000002B` (no hit) with rs_valid=00: immediate handshake, accept=0, scoreboard unchanged. Issue `0x0400702B` with rs_valid=00: `issue_ready_o`=0 until rs_valid[0]=1.
- Fill with 4 accepted instructions, `disp_ready_i`=0: `issue_ready_o`=0. Commit all, then release one dispatch: ready rises the following cycle. Order is preserved across pointer wrap.
- Commit ids 0 (kill=1) and 1 (kill=0): id 0 is dropped silently and id 1 is dispatched next. With stats enabled, `stat_kill_o`=1.
- Commit id 7 while the head PEND id is 5: `err_o`=1 and stays 1, entry 5 stays PEND. Then assert reset: `err_o`=0 and the scoreboard is empty.

Source files
------------

// File: rtl/xif_copro_issue_predecoder.sv
// XIF coprocessor issue predecoder: first-match offload table, registered issue response and an
// in-order commit scoreboard feeding dispatch. Optional statistics: XIF_COPRO_PRD_STATS_EN.

package xif_copro_issue_predecoder_pkg;

  typedef struct packed {
    logic       writeback;
    logic       loadstore;
    logic [1:0] use_gprs;
  } prd_rsp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] instr_mask;
    prd_rsp_t    prd_rsp;
  } offload_instr_t;

  // Entries 1 and 2 overlap on funct7=3/funct3=7 so priority is observable.
  localparam offload_instr_t OFFLOAD_INSTR_DEFAULT [3] = '{
    '{instr: 32'h0400_702B, instr_mask: 32'hFE00_707F,
      prd_rsp: '{writeback: 1'b0, loadstore: 1'b0, use_gprs: 2'b01}},
    '{instr: 32'h0600_702B, instr_mask: 32'hFE00_707F,
      prd_rsp: '{writeback: 1'b1, loadstore: 1'b0, use_gprs: 2'b11}},
    '{instr: 32'h0600_002B, instr_mask: 32'hFE00_007F,
      prd_rsp: '{writeback: 1'b1, loadstore: 1'b1, use_gprs: 2'b00}}
  };

endpackage

module xif_copro_issue_predecoder
  import xif_copro_issue_predecoder_pkg::*;
#(
  parameter int unsigned    NUM_INSTR                = 3,
  parameter offload_instr_t OFFLOAD_INSTR [NUM_INSTR] = OFFLOAD_INSTR_DEFAULT,
  parameter int unsigned    ID_WIDTH                 = 4,
  parameter int unsigned    SB_DEPTH                 = 4,
  parameter int unsigned    IDX_WIDTH                = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [31:0]          issue_instr_i,
  input  logic [ID_WIDTH-1:0]  issue_id_i,
  input  logic [1:0][31:0]     issue_rs_i,
  input  logic [1:0]           issue_rs_valid_i,
  output logic                 resp_valid_o,
  output logic [ID_WIDTH-1:0]  resp_id_o,
  output logic                 resp_accept_o,
  output logic                 resp_writeback_o,
  output logic                 resp_loadstore_o,
  input  logic                 commit_valid_i,
  input  logic [ID_WIDTH-1:0]  commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 disp_valid_o,
  input  logic                 disp_ready_i,
  output logic [31:0]          disp_instr_o,
  output logic [ID_WIDTH-1:0]  disp_id_o,
  output logic [IDX_WIDTH-1:0] disp_idx_o,
  output logic [1:0][31:0]     disp_rs_o,
  output logic                 err_o,
  output logic [31:0]          stat_accept_o,
  output logic [31:0]          stat_reject_o,
  output logic [31:0]          stat_kill_o
);

  localparam int unsigned AddrW = $clog2(SB_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [1:0] {StPend, StCommit, StKill} sb_state_e;

  // Table match
  logic                 hit;
  logic [IDX_WIDTH-1:0] hit_idx;
  prd_rsp_t             hit_rsp;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_rsp = '0;
    for (int unsigned i = 0; i < NUM_INSTR; i++) begin
      if (!hit && ((issue_instr_i & OFFLOAD_INSTR[i].instr_mask) == OFFLOAD_INSTR[i].instr)) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(i);
        hit_rsp = OFFLOAD_INSTR[i].prd_rsp;
      end
    end
  end

  // Scoreboard storage and pointers
  logic [31:0]          instr_q [SB_DEPTH];
  logic [31:0]          instr_d [SB_DEPTH];
  logic [ID_WIDTH-1:0]  id_q    [SB_DEPTH];
  logic [ID_WIDTH-1:0]  id_d    [SB_DEPTH];
  logic [IDX_WIDTH-1:0] idx_q   [SB_DEPTH];
  logic [IDX_WIDTH-1:0] idx_d   [SB_DEPTH];
  logic [1:0][31:0]     rs_q    [SB_DEPTH];
  logic [1:0][31:0]     rs_d    [SB_DEPTH];
  sb_state_e            state_q [SB_DEPTH];
  sb_state_e            state_d [SB_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] cm_ptr_q, cm_ptr_d;

  logic [AddrW-1:0] wr_addr, rd_addr, cm_addr;
  logic             full, empty, pend_any, ops_ready;
  logic             issue_hs, push, pop, kill_pop;
  logic             cm_match, cm_err;
  sb_state_e        head_st;

  assign wr_addr  = wr_ptr_q[AddrW-1:0];
  assign rd_addr  = rd_ptr_q[AddrW-1:0];
  assign cm_addr  = cm_ptr_q[AddrW-1:0];

  assign full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) && (wr_addr == rd_addr);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pend_any = (cm_ptr_q != wr_ptr_q);

  // No hit leaves use_gprs at zero, so operands never stall an unmatched instruction.
  assign ops_ready     = &(~hit_rsp.use_gprs | issue_rs_valid_i);
  assign issue_ready_o = !full && (!hit || ops_ready);
  assign issue_hs      = issue_valid_i && issue_ready_o;
  assign push          = issue_hs && hit;

  assign head_st  = state_q[rd_addr];
  assign kill_pop = !empty && (head_st == StKill);
  assign pop      = kill_pop || (!empty && (head_st == StCommit) && disp_ready_i);

  assign cm_match = commit_valid_i && pend_any && (id_q[cm_addr] == commit_id_i);
  assign cm_err   = commit_valid_i && !cm_match;

  always_comb begin
    instr_d  = instr_q;
    id_d     = id_q;
    idx_d    = idx_q;
    rs_d     = rs_q;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cm_ptr_d = cm_ptr_q;
    if (push) begin
      instr_d[wr_addr] = issue_instr_i;
      id_d[wr_addr]    = issue_id_i;
      idx_d[wr_addr]   = hit_idx;
      for (int k = 0; k < 2; k++) begin
        rs_d[wr_addr][k] = hit_rsp.use_gprs[k] ? issue_rs_i[k] : 32'h0;
      end
      state_d[wr_addr] = StPend;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    // The committed slot is always pending, so it never aliases the slot being pushed.
    if (cm_match) begin
      state_d[cm_addr] = commit_kill_i ? StKill : StCommit;
      cm_ptr_d         = cm_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q  <= '{default: '0};
      id_q     <= '{default: '0};
      idx_q    <= '{default: '0};
      rs_q     <= '{default: '0};
      state_q  <= '{default: StPend};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
    end else begin
      instr_q  <= instr_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      rs_q     <= rs_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cm_ptr_q <= cm_ptr_d;
    end
  end

  assign disp_valid_o = !empty && (head_st == StCommit);
  assign disp_instr_o = instr_q[rd_addr];
  assign disp_id_o    = id_q[rd_addr];
  assign disp_idx_o   = idx_q[rd_addr];
  assign disp_rs_o    = rs_q[rd_addr];

  // Issue response and sticky error
  logic                resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;
  logic                resp_accept_q, resp_accept_d;
  logic                resp_wb_q, resp_wb_d;
  logic                resp_ls_q, resp_ls_d;
  logic                err_q, err_d;

  always_comb begin
    resp_valid_d  = issue_hs;
    resp_id_d     = resp_id_q;
    resp_accept_d = resp_accept_q;
    resp_wb_d     = resp_wb_q;
    resp_ls_d     = resp_ls_q;
    if (issue_hs) begin
      resp_id_d     = issue_id_i;
      resp_accept_d = hit;
      resp_wb_d     = hit && hit_rsp.writeback;
      resp_ls_d     = hit && hit_rsp.loadstore;
    end
    err_d = err_q || cm_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_accept_q <= 1'b0;
      resp_wb_q     <= 1'b0;
      resp_ls_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_accept_q <= resp_accept_d;
      resp_wb_q     <= resp_wb_d;
      resp_ls_q     <= resp_ls_d;
      err_q         <= err_d;
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_id_o        = resp_id_q;
  assign resp_accept_o    = resp_accept_q;
  assign resp_writeback_o = resp_wb_q;
  assign resp_loadstore_o = resp_ls_q;
  assign err_o            = err_q;

`ifdef XIF_COPRO_PRD_STATS_EN
  logic [31:0] stat_accept_q, stat_accept_d;
  logic [31:0] stat_reject_q, stat_reject_d;
  logic [31:0] stat_kill_q, stat_kill_d;

  always_comb begin
    stat_accept_d = stat_accept_q;
    stat_reject_d = stat_reject_q;
    stat_kill_d   = stat_kill_q;
    if (push && (stat_accept_q != '1)) begin
      stat_accept_d = stat_accept_q + 32'd1;
    end
    if (issue_hs && !hit && (stat_reject_q != '1)) begin
      stat_reject_d = stat_reject_q + 32'd1;
    end
    if (kill_pop && (stat_kill_q != '1)) begin
      stat_kill_d = stat_kill_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_accept_q <= '0;
      stat_reject_q <= '0;
      stat_kill_q   <= '0;
    end else begin
      stat_accept_q <= stat_accept_d;
      stat_reject_q <= stat_reject_d;
      stat_kill_q   <= stat_kill_d;
    end
  end

  assign stat_accept_o = stat_accept_q;
  assign stat_reject_o = stat_reject_q;
  assign stat_kill_o   = stat_kill_q;
`else
  assign stat_accept_o = '0;
  assign stat_reject_o = '0;
  assign stat_kill_o   = '0;
`endif

endmodule

// File: tb/tb_xif_copro_issue_predecoder.sv
// Bench for xif_copro_issue_predecoder: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the offload table and commit scoreboard.

module tb_xif_copro_issue_predecoder;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             issue_valid_i, issue_ready_o;
  logic [31:0]      issue_instr_i;
  logic [3:0]       issue_id_i;
  logic [1:0][31:0] issue_rs_i;
  logic [1:0]       issue_rs_valid_i;
  logic             resp_valid_o, resp_accept_o, resp_writeback_o, resp_loadstore_o;
  logic [3:0]       resp_id_o;
  logic             commit_valid_i, commit_kill_i;
  logic [3:0]       commit_id_i;
  logic             disp_valid_o, disp_ready_i;
  logic [31:0]      disp_instr_o;
  logic [3:0]       disp_id_o;
  logic [1:0]       disp_idx_o;
  logic [1:0][31:0] disp_rs_o;
  logic             err_o;
  logic [31:0]      stat_accept_o, stat_reject_o, stat_kill_o;

  always #5 clk_i = ~clk_i;

  xif_copro_issue_predecoder dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_instr_i    (issue_instr_i),
    .issue_id_i       (issue_id_i),
    .issue_rs_i       (issue_rs_i),
    .issue_rs_valid_i (issue_rs_valid_i),
    .resp_valid_o     (resp_valid_o),
    .resp_id_o        (resp_id_o),
    .resp_accept_o    (resp_accept_o),
    .resp_writeback_o (resp_writeback_o),
    .resp_loadstore_o (resp_loadstore_o),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .disp_valid_o     (disp_valid_o),
    .disp_ready_i     (disp_ready_i),
    .disp_instr_o     (disp_instr_o),
    .disp_id_o        (disp_id_o),
    .disp_idx_o       (disp_idx_o),
    .disp_rs_o        (disp_rs_o),
    .err_o            (err_o),
    .stat_accept_o    (stat_accept_o),
    .stat_reject_o    (stat_reject_o),
    .stat_kill_o      (stat_kill_o)
  );

  // Reference copy of the default offload table.
  logic [31:0] m_instr [3] = '{32'h0400_702B, 32'h0600_702B, 32'h0600_002B};
  logic [31:0] m_mask  [3] = '{32'hFE00_707F, 32'hFE00_707F, 32'hFE00_007F};
  logic [1:0]  m_use   [3] = '{2'b01, 2'b11, 2'b00};
  logic        m_wb    [3] = '{1'b0, 1'b1, 1'b1};
  logic        m_ls    [3] = '{1'b0, 1'b0, 1'b1};

  // st: 0 = waiting for commit, 1 = committed, 2 = killed
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  id;
    int          idx;
    logic [31:0] rs0;
    logic [31:0] rs1;
    int          st;
  } ent_t;

  ent_t        sbq[$];
  logic        e_rv, e_acc, e_wb, e_ls, e_err;
  logic [3:0]  e_rid;
  logic [31:0] e_sacc, e_srej, e_skill;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_hit(input logic [31:0] ins);
    for (int i = 0; i < 3; i++) begin
      if ((ins & m_mask[i]) == m_instr[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oldest_pend();
    for (int k = 0; k < sbq.size(); k++) begin
      if (sbq[k].st == 0) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_clear();
    sbq.delete();
    e_rv = 0; e_acc = 0; e_wb = 0; e_ls = 0; e_err = 0; e_rid = '0;
    e_sacc = '0; e_srej = '0; e_skill = '0;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs_i       = '0;
    issue_rs_valid_i = '0;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    disp_ready_i     = 1'b0;
  endtask

  task automatic set_issue(input logic [31:0] ins, input logic [3:0] id, input logic [1:0] rsv,
                           input logic [31:0] r0, input logic [31:0] r1);
    issue_valid_i    = 1'b1;
    issue_instr_i    = ins;
    issue_id_i       = id;
    issue_rs_valid_i = rsv;
    issue_rs_i[0]    = r0;
    issue_rs_i[1]    = r1;
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  // Asynchronous reset mid-cycle; called just after a rising edge.
  task automatic do_reset();
    idle();
    #2 rst_ni = 1'b0;
    #1;
    model_clear();
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_disp_valid", disp_valid_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_ready", issue_ready_o, 1);
    check_eq("rst_stats", stat_accept_o | stat_reject_o | stat_kill_o, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Check all outputs against the model mid-cycle, then advance the model by one clock.
  task automatic step();
    int  h, j;
    bit  rdy, fire, popf, dv;
    @(negedge clk_i);
    h   = find_hit(issue_instr_i);
    rdy = (sbq.size() < 4) && ((h < 0) || ((m_use[h] & ~issue_rs_valid_i) == 2'b00));
    check_eq("issue_ready", issue_ready_o, rdy);
    check_eq("resp_valid", resp_valid_o, e_rv);
    if (e_rv) begin
      check_eq("resp_id", resp_id_o, e_rid);
      check_eq("resp_flags", {resp_accept_o, resp_writeback_o, resp_loadstore_o},
               {e_acc, e_wb, e_ls});
    end
    dv = (sbq.size() > 0) && (sbq[0].st == 1);
    check_eq("disp_valid", disp_valid_o, dv);
    if (dv) begin
      check_eq("disp_instr", disp_instr_o, sbq[0].instr);
      check_eq("disp_id", disp_id_o, sbq[0].id);
      check_eq("disp_idx", disp_idx_o, sbq[0].idx);
      check_eq("disp_rs0", disp_rs_o[0], sbq[0].rs0);
      check_eq("disp_rs1", disp_rs_o[1], sbq[0].rs1);
    end
    check_eq("err", err_o, e_err);
`ifdef XIF_COPRO_PRD_STATS_EN
    check_eq("stat_accept", stat_accept_o, e_sacc);
    check_eq("stat_reject", stat_reject_o, e_srej);
    check_eq("stat_kill", stat_kill_o, e_skill);
`else
    check_eq("stats_tied", stat_accept_o | stat_reject_o | stat_kill_o, 0);
`endif
    fire = issue_valid_i && rdy;
    popf = (sbq.size() > 0) && (((sbq[0].st == 1) && disp_ready_i) || (sbq[0].st == 2));
    if (commit_valid_i) begin
      j = oldest_pend();
      if ((j >= 0) && (sbq[j].id == commit_id_i)) sbq[j].st = commit_kill_i ? 2 : 1;
      else e_err = 1'b1;
    end
    if (popf) begin
      if (sbq[0].st == 2) e_skill = sat_inc(e_skill);
      void'(sbq.pop_front());
    end
    e_rv = fire;
    if (fire) begin
      e_rid = issue_id_i;
      e_acc = (h >= 0);
      e_wb  = (h >= 0) ? m_wb[h] : 1'b0;
      e_ls  = (h >= 0) ? m_ls[h] : 1'b0;
      if (h >= 0) begin
        sbq.push_back('{instr: issue_instr_i, id: issue_id_i, idx: h,
                        rs0: m_use[h][0] ? issue_rs_i[0] : 32'h0,
                        rs1: m_use[h][1] ? issue_rs_i[1] : 32'h0, st: 0});
        e_sacc = sat_inc(e_sacc);
      end else begin
        e_srej = sat_inc(e_srej);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic randomize_inputs();
    int          kind, j;
    logic [31:0] r;
    r             = $urandom;
    kind          = $urandom_range(0, 4);
    issue_valid_i = ($urandom_range(0, 3) != 0);
    if (kind < 3) issue_instr_i = m_instr[kind] | (r & ~m_mask[kind]);
    else issue_instr_i = r;
    issue_id_i       = 4'($urandom);
    issue_rs_i[0]    = $urandom;
    issue_rs_i[1]    = $urandom;
    issue_rs_valid_i = 2'($urandom);
    disp_ready_i     = 1'($urandom);
    commit_valid_i   = 1'b0;
    commit_kill_i    = ($urandom_range(0, 3) == 0);
    commit_id_i      = '0;
    j = oldest_pend();
    if ((j >= 0) && ($urandom_range(0, 2) == 0)) begin
      commit_valid_i = 1'b1;
      commit_id_i    = sbq[j].id;
    end else if ($urandom_range(0, 49) == 0) begin
      commit_valid_i = 1'b1;
      commit_id_i    = 4'($urandom);
    end
  endtask

  initial begin
    idle();
    model_clear();
    @(posedge clk_i);
    #1;
    do_reset();

    // Basic accept, commit and dispatch
    set_issue(32'h0400_702B, 4'd3, 2'b01, 32'hA5A5_0001, 32'h1234_5678);
    step();
    issue_valid_i = 1'b0;
    check_eq("t1_resp_valid", resp_valid_o, 1);
    check_eq("t1_accept", resp_accept_o, 1);
    check_eq("t1_writeback", resp_writeback_o, 0);
    check_eq("t1_resp_id", resp_id_o, 3);
    set_commit(4'd3, 1'b0);
    step();
    commit_valid_i = 1'b0;
    check_eq("t1_disp_valid", disp_valid_o, 1);
    check_eq("t1_disp_idx", disp_idx_o, 0);
    check_eq("t1_disp_instr", disp_instr_o, 32'h0400_702B);
    check_eq("t1_disp_rs0", disp_rs_o[0], 32'hA5A5_0001);
    check_eq("t1_disp_rs1_zero", disp_rs_o[1], 0);
    disp_ready_i = 1'b1;
    step();
    disp_ready_i = 1'b0;

    // Lowest-index match wins
    set_issue(32'h0600_702B, 4'd4, 2'b11, 32'h1111_1111, 32'h2222_2222);
    step();
    issue_valid_i = 1'b0;
    set_commit(4'd4, 1'b0);
    step();
    commit_valid_i = 1'b0;
    check_eq("t2_disp_idx", disp_idx_o, 1);
    disp_ready_i = 1'b1;
    step();
    disp_ready_i = 1'b0;

    // Reject without operands; operand stall on a hit
    set_issue(32'h0000_002B, 4'd6, 2'b00, 32'h0, 32'h0);
    #1 check_eq("t3_nohit_ready", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
    check_eq("t3_nohit_accept", resp_accept_o, 0);
    check_eq("t3_nohit_flags", {resp_writeback_o, resp_loadstore_o}, 0);
    set_issue(32'h0400_702B, 4'd5, 2'b00, 32'hCAFE_0005, 32'h0);
    #1 check_eq("t3_stall_ready", issue_ready_o, 0);
    step();
    step();
    issue_rs_valid_i = 2'b01;
    #1 check_eq("t3_rs_ready", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
    set_commit(4'd5, 1'b0);
    step();
    commit_valid_i = 1'b0;
    disp_ready_i   = 1'b1;
    step();
    disp_ready_i = 1'b0;

    // Fill, no same-cycle bypass on pop, then wrap
    for (int i = 0; i < 4; i++) begin
      set_issue(32'h0600_002B | (32'(i) << 12), 4'(8 + i), 2'b00, 32'h0, 32'h0);
      step();
    end
    set_issue(32'h0600_002B, 4'd12, 2'b00, 32'h0, 32'h0);
    #1 check_eq("t4_full_ready", issue_ready_o, 0);
    step();
    issue_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_commit(4'(8 + i), 1'b0);
      step();
    end
    commit_valid_i = 1'b0;
    disp_ready_i   = 1'b1;
    set_issue(32'h0600_002B, 4'd12, 2'b00, 32'h0, 32'h0);
    #1 check_eq("t4_nobypass_ready", issue_ready_o, 0);
    step();
    disp_ready_i = 1'b0;
    check_eq("t4_ready_after_pop", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
    set_commit(4'd12, 1'b0);
    step();
    commit_valid_i = 1'b0;
    disp_ready_i   = 1'b1;
    repeat (5) step();
    disp_ready_i = 1'b0;

    // Killed entry dropped silently
    set_issue(32'h0600_002B, 4'd0, 2'b00, 32'h0, 32'h0);
    step();
    set_issue(32'h0600_002B, 4'd1, 2'b00, 32'h0, 32'h0);
    step();
    issue_valid_i = 1'b0;
    set_commit(4'd0, 1'b1);
    step();
    set_commit(4'd1, 1'b0);
    step();
    commit_valid_i = 1'b0;
    check_eq("t5_disp_valid", disp_valid_o, 1);
    check_eq("t5_disp_id", disp_id_o, 1);
`ifdef XIF_COPRO_PRD_STATS_EN
    check_eq("t5_stat_kill", stat_kill_o, 1);
`endif
    disp_ready_i = 1'b1;
    step();
    disp_ready_i = 1'b0;

    // Mismatched commit sets sticky error; reset clears it
    set_issue(32'h0600_002B, 4'd5, 2'b00, 32'h0, 32'h0);
    step();
    issue_valid_i = 1'b0;
    set_commit(4'd7, 1'b0);
    step();
    commit_valid_i = 1'b0;
    check_eq("t6_err_set", err_o, 1);
    repeat (3) step();
    check_eq("t6_err_sticky", err_o, 1);
    check_eq("t6_still_pend", disp_valid_o, 0);
    do_reset();
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      step();
      if (c == 1500) do_reset();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
